ci_dma_controller: RTL
======================

# ci_dma_controller

DMA engine that moves word blocks between the system bus and the 512×32 dual-port CI scratch memory. It is configured and polled through its own custom-instruction slot and drives memory port B (clock B, write enable B, address B, data in/out B), while the CPU keeps port A through the existing memory custom instruction. It acts as a single-word bus master with a request/grant arbiter interface.

## Interface
- customInstructionId, 8'h01, iseId value this block answers to

- clock  in  1  system clock; also drives memory clockB
- reset  in  1  asynchronous, active-low reset
- start  in  1  CI start strobe
- valueA  in  32  CI operand A: [12:10] register select, [9] write enable
- valueB  in  32  CI operand B: write data
- iseId  in  8  CI identifier
- done  out  1  CI completion
- result  out  32  CI read data
- addressB  out  9  memory port B address
- dataInB  out  32  memory port B write data
- writeEnableB  out  1  memory port B write enable
- dataOutB  in  32  memory port B read data, valid 1 cycle after address
- busRequest  out  1  bus ownership request
- busGrant  in  1  bus ownership grant
- busValid  out  1  transfer request; qualifies busAddress, busReadNotWrite and busWriteData
- busReadNotWrite  out  1  1 = read from bus, 0 = write to bus
- busAddress  out  32  byte address; bits [1:0] always 0
- busWriteData  out  32  write data
- busReadData  in  32  read data, valid with busReady
- busReady  in  1  transfer accepted/completed this cycle
- busError  in  1  qualified by busReady; transfer failed

## Operation
- A CI access is selected when iseId == customInstructionId and start = 1.
- CI registers are selected by valueA[12:10]:
  - 1: bus start address, read/write. Bits [1:0] are forced to 0.
  - 2: memory start address, 9 bits, read/write.
  - 3: block size in words, 10 bits, read/write. Range 0..512.
  - 4: control on write, status on read.
- Control write, valueB[1:0]:
  - 01: start bus→mem.
  - 10: start mem→bus.
  - 00 or 11: no start.
  - Every control write clears the error flag.
- Status read returns {30'b0, error, busy}.
- Unused select values: a read returns 0 and a write is ignored.
- While busy, writes to selects 1–4 are ignored. Registers and the error flag are unchanged.
- Start with size 0: no bus activity; busy stays 0.
- State machine:
  - IDLE: wait for a valid start.
  - REQ: hold busRequest = 1 until busGrant = 1.
  - bus→mem path, RD_BUS: busValid = 1, busReadNotWrite = 1. On busReady, writeEnableB = 1 combinationally, dataInB = busReadData, addressB = current memory address.
  - mem→bus path, FETCH: addressB = current memory address, for 1 cycle.
  - mem→bus path, WR_BUS: busValid = 1, busReadNotWrite = 0, busWriteData = dataOutB. addressB is held so the data stays stable. Exit on busReady.
  - After each accepted word: bus address += 4, memory address += 1 modulo 512 (wraps 511→0), remaining −= 1.
  - When remaining reaches 0 → FIN. Otherwise go back to RD_BUS or FETCH.
  - FIN: drop busRequest and busValid, clear busy → IDLE.
- busRequest stays high for the whole block; there is no re-arbitration between words.
- busError with busReady:
  - The word is discarded; no memory write.
  - error = 1, then FIN.
  - Working counters are frozen, so the configured registers hold the original values.
- Working copies of address and count are loaded at start. The CI-visible config registers are never modified by a transfer.

## Timing
- Reset values:
  - state IDLE; all config registers, working counters, busy and error are 0.
  - busRequest, busValid, writeEnableB, addressB, dataInB, busAddress and busWriteData are 0.
- Outside an active word, busReadNotWrite is 0.
- CI handshake:
  - done = 1 in the same cycle as a selected access, for every select value.
  - result is combinational and is 0 whenever done = 0.
  - Register writes take effect at the clock edge ending that cycle.
- Start timing:
  - A control write at edge E makes busy = 1 from E.
  - busRequest = 1 in the cycle after E, which is the REQ state.
- With busGrant already 1, the first busValid appears 2 cycles after E.
- Throughput with busReady always 1:
  - bus→mem: 1 word/cycle.
  - mem→bus: 1 word per 2 cycles.
- Completion: busy falls at the edge that ends the FIN cycle.
- busValid and its qualified fields are held stable until busReady.
- busGrant deasserted mid-block is ignored. The arbiter must not revoke grant while busRequest = 1.
- Asynchronous reset mid-transfer aborts immediately: all outputs return to reset values with no further memory writes.

## Test plan
- Config readback: write bus address 0x1000_0003, memory address 0x1F0, size 5; read back 0x1000_0000, 0x1F0, 5; status 0; done = 1 on each access.
- bus→mem, 4 words from 0x2000 into memory 0x010, busReady tied 1:
  - Memory 0x010..0x013 holds the bus data.
  - busAddress sequence is 0x2000, 0x2004, 0x2008, 0x200C.
  - busy clears and busRequest drops.
- mem→bus wrap: memory 0x1FE, size 3, with 1-cycle busReady stalls. Bus writes carry memory words 0x1FE, 0x1FF, 0x000 in that order; data is held stable during each stall.
- Error: bus→mem size 4 with busError on the 2nd word. Only 1 memory write occurs; status = 2'b10. A control write of 00 clears it, and status reads 0.
- Busy protection and size 0:
  - While busy, writes to the size and control registers are ignored; the transfer is unaltered.
  - A start with size 0 produces no busRequest, and status reads 0.
- Reset mid-transfer: assert reset during WR_BUS. busValid, busRequest and writeEnableB go to 0 immediately, and all registers read 0 after release.

Source files
------------

// File: rtl/ci_dma_controller.sv
// ci_dma_controller: block DMA between system bus and CI scratch memory.
// Configured through its CI slot; owns memory port B while transferring.
module ci_dma_controller #(
  parameter logic [7:0] customInstructionId = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  iseId,
  output logic        done,
  output logic [31:0] result,
  output logic [8:0]  addressB,
  output logic [31:0] dataInB,
  output logic        writeEnableB,
  input  logic [31:0] dataOutB,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        busValid,
  output logic        busReadNotWrite,
  output logic [31:0] busAddress,
  output logic [31:0] busWriteData,
  input  logic [31:0] busReadData,
  input  logic        busReady,
  input  logic        busError
);

  typedef enum logic [2:0] {
    IDLE, REQ, RD_BUS, FETCH, WR_BUS, FIN
  } state_t;

  state_t state, state_nx;

  logic [31:0] cfg_bus;
  logic [8:0]  cfg_mem;
  logic [9:0]  cfg_size;
  logic        busy, error, to_bus;
  logic [31:0] work_bus;
  logic [8:0]  work_mem;
  logic [9:0]  work_cnt;
  logic        sel, cfg_we, ctl_we, go;
  logic        accept, fail, last;
  logic [2:0]  reg_sel;
  logic        unused_ci;

  assign unused_ci = ^{valueA[31:13], valueA[8:0]};

  assign sel     = start && (iseId == customInstructionId);
  assign reg_sel = valueA[12:10];
  assign cfg_we  = sel && valueA[9] && !busy;
  assign ctl_we  = cfg_we && (reg_sel == 3'd4);
  assign go      = ctl_we && (cfg_size != 10'd0) &&
                   (valueB[1:0] == 2'b01 || valueB[1:0] == 2'b10);
  assign done    = sel;
  assign accept  = busValid && busReady;
  assign fail    = accept && busError;
  assign last    = (work_cnt == 10'd1);

  // CI read mux; result is zero outside a selected access
  always_comb begin
    result = '0;
    if (sel) begin
      case (reg_sel)
        3'd1:    result = cfg_bus;
        3'd2:    result = {23'd0, cfg_mem};
        3'd3:    result = {22'd0, cfg_size};
        3'd4:    result = {30'd0, error, busy};
        default: result = '0;
      endcase
    end
  end

  // Next state and all bus/memory outputs, decoded from state
  always_comb begin
    state_nx        = state;
    busRequest      = 1'b0;
    busValid        = 1'b0;
    busReadNotWrite = 1'b0;
    busAddress      = '0;
    busWriteData    = '0;
    addressB        = '0;
    dataInB         = '0;
    writeEnableB    = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) state_nx = REQ;
      end
      REQ: begin
        busRequest = 1'b1;
        if (busGrant) state_nx = to_bus ? FETCH : RD_BUS;
      end
      RD_BUS: begin
        busRequest      = 1'b1;
        busValid        = 1'b1;
        busReadNotWrite = 1'b1;
        busAddress      = work_bus;
        if (busReady) begin
          if (busError) begin
            state_nx = FIN;
          end else begin
            writeEnableB = 1'b1;
            addressB     = work_mem;
            dataInB      = busReadData;
            if (last) state_nx = FIN;
          end
        end
      end
      FETCH: begin
        busRequest = 1'b1;
        addressB   = work_mem;
        state_nx   = WR_BUS;
      end
      WR_BUS: begin
        busRequest   = 1'b1;
        busValid     = 1'b1;
        busAddress   = work_bus;
        busWriteData = dataOutB;
        addressB     = work_mem;
        if (busReady) state_nx = (busError || last) ? FIN : FETCH;
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // CI-visible configuration, frozen while a block is running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_bus  <= '0;
      cfg_mem  <= '0;
      cfg_size <= '0;
    end else if (cfg_we) begin
      case (reg_sel)
        3'd1:    cfg_bus  <= {valueB[31:2], 2'b00};
        3'd2:    cfg_mem  <= valueB[8:0];
        3'd3:    cfg_size <= valueB[9:0];
        default: ;
      endcase
    end
  end

  // Busy/error flags and the latched transfer direction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      error  <= 1'b0;
      to_bus <= 1'b0;
    end else begin
      if (go)                busy <= 1'b1;
      else if (state == FIN) busy <= 1'b0;
      if (ctl_we)    error <= 1'b0;
      else if (fail) error <= 1'b1;
      if (go) to_bus <= valueB[1];
    end
  end

  // Working copies; advance only on a word accepted without error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work_bus <= '0;
      work_mem <= '0;
      work_cnt <= '0;
    end else if (go) begin
      work_bus <= cfg_bus;
      work_mem <= cfg_mem;
      work_cnt <= cfg_size;
    end else if (accept && !busError) begin
      work_bus <= work_bus + 32'd4;
      work_mem <= work_mem + 9'd1;
      work_cnt <= work_cnt - 10'd1;
    end
  end

endmodule
